// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: FSM states, instruction
// field positions and the NZCV flag order used by both sequencer and ALU.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   localparam int INSTR_W  = 9;
   localparam int HALT_BIT = 8;
   localparam int OP_LSB   = 5;
   localparam int OP_W     = 3;
   localparam int RD_LSB   = 3;
   localparam int RS_LSB   = 1;
   localparam int REG_W    = 2;
   localparam int S_BIT    = 0;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic             halt;
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs;
      logic             s;
   } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Splits a raw instruction word into halt/op/rd/rs/S fields.
// Purely combinational; no handshake.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output instr_t             fields
);

   always_comb begin
      fields      = '0;
      fields.halt = instr[HALT_BIT];
      fields.op   = instr[OP_LSB +: OP_W];
      fields.rd   = instr[RD_LSB +: REG_W];
      fields.rs   = instr[RS_LSB +: REG_W];
      fields.s    = instr[S_BIT];
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: FETCH -> EXEC -> WB, three cycles per instruction.
// Backpressure: instr_ready only in FETCH; a stalled fetch waits with pc held.
module control_unit
   import cpu_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int RESET_PC = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 instr_valid,
   input  logic [INSTR_W-1:0]   instr,
   output logic                 instr_ready,
   output logic [PC_W-1:0]      pc,
   output logic [OP_W-1:0]      alu_op,
   output logic [REG_W-1:0]     rs_a,
   output logic [REG_W-1:0]     rs_b,
   input  logic [3:0]           alu_nzcv,
   output logic                 rf_we,
   output logic [REG_W-1:0]     rf_waddr,
   output logic [3:0]           flags,
   output logic                 busy,
   output logic                 halted
);

   localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

   state_t state;
   state_t state_nxt;
   instr_t dec;
   logic   ir_s;
   logic   fetch_hs;

   instr_decode u_decode (
      .instr  (instr),
      .fields (dec)
   );

   assign fetch_hs = (state == ST_FETCH) && instr_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_FETCH;
         ST_FETCH: if (instr_valid) state_nxt = dec.halt ? ST_HALT : ST_EXEC;
         ST_EXEC:  state_nxt = ST_WB;
         ST_WB:    state_nxt = ST_FETCH;
         ST_HALT:  if (start) state_nxt = ST_FETCH;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state == ST_FETCH);
      rf_we       = (state == ST_WB);
      busy        = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WB);
      halted      = (state == ST_HALT);
   end

   // Operand fields load at the handshake so they are already valid on EXEC entry;
   // a HALT word leaves them untouched so the last executed operation stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= PC_INIT;
         ir_s   <= 1'b0;
         alu_op <= '0;
         rs_a   <= '0;
         rs_b   <= '0;
         flags  <= '0;
      end else begin
         if (fetch_hs) begin
            ir_s <= dec.s;
            if (!dec.halt) begin
               alu_op <= dec.op;
               rs_a   <= dec.rd;
               rs_b   <= dec.rs;
            end
         end
         if (state == ST_WB) begin
            pc <= pc + PC_W'(1);
            if (ir_s) flags <= alu_nzcv;
         end
         if ((state == ST_HALT) && start) pc <= PC_INIT;
      end
   end

   assign rf_waddr = rs_a;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against an instruction-level model of
// pc, flags and the last executed operand fields.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       instr_valid;
   logic [8:0] instr;
   logic       instr_ready;
   logic [7:0] pc;
   logic [2:0] alu_op;
   logic [1:0] rs_a;
   logic [1:0] rs_b;
   logic [3:0] alu_nzcv;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [3:0] flags;
   logic       busy;
   logic       halted;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_pc;
   logic [3:0] m_flags;
   logic [2:0] m_op;
   logic [1:0] m_rd;
   logic [1:0] m_rs;

   control_unit #(.PC_W(8), .RESET_PC(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .pc          (pc),
      .alu_op      (alu_op),
      .rs_a        (rs_a),
      .rs_b        (rs_b),
      .alu_nzcv    (alu_nzcv),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .flags       (flags),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] next_pc(input logic [7:0] p);
      int t;
      t = (int'(p) + 1) % 256;
      return 8'(t);
   endfunction

   function automatic logic [8:0] rand_instr();
      logic [8:0] w;
      w = 9'($urandom_range(0, 255));
      return w;
   endfunction

   // Enters and leaves on a falling edge with the DUT in FETCH (HALT words leave it in HALT).
   task automatic run_instr(input logic [8:0] ins, input int stall,
                            input logic [3:0] nzcv, input bit poke);
      if ({instr_ready, busy, halted, pc} !== {1'b1, 1'b1, 1'b0, m_pc}) begin
         failures++;
         $display("FAIL fetch_entry: rdy/busy/halt/pc=%b/%b/%b/%h want 1/1/0/%h",
                  instr_ready, busy, halted, pc, m_pc);
      end
      checks++;
      for (int i = 0; i < stall; i++) begin
         instr_valid = 1'b0;
         instr       = 9'($urandom);
         @(negedge clk);
         if ({instr_ready, rf_we, pc} !== {1'b1, 1'b0, m_pc}) begin
            failures++;
            $display("FAIL stall: rdy/we/pc=%b/%b/%h want 1/0/%h", instr_ready, rf_we, pc, m_pc);
         end
         checks++;
      end
      instr_valid = 1'b1;
      instr       = ins;
      alu_nzcv    = 4'($urandom);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 9'($urandom);
      if (ins[8]) begin
         if ({halted, busy, instr_ready, rf_we, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, m_pc}) begin
            failures++;
            $display("FAIL halt_entry: halt/busy/rdy/we/pc=%b/%b/%b/%b/%h want 1/0/0/0/%h",
                     halted, busy, instr_ready, rf_we, pc, m_pc);
         end
         checks++;
         if ({alu_op, rs_a, rs_b, rf_waddr} !== {m_op, m_rd, m_rs, m_rd}) begin
            failures++;
            $display("FAIL halt_fields: got %h want %h", {alu_op, rs_a, rs_b, rf_waddr},
                     {m_op, m_rd, m_rs, m_rd});
         end
         checks++;
         return;
      end
      m_op     = ins[7:5];
      m_rd     = ins[4:3];
      m_rs     = ins[2:1];
      start    = poke;
      alu_nzcv = nzcv;
      if ({instr_ready, busy, rf_we} !== 3'b010) begin
         failures++;
         $display("FAIL exec_ctrl: rdy/busy/we=%b/%b/%b want 0/1/0", instr_ready, busy, rf_we);
      end
      checks++;
      if ({alu_op, rs_a, rs_b, rf_waddr} !== {m_op, m_rd, m_rs, m_rd}) begin
         failures++;
         $display("FAIL exec_fields: got %h want %h", {alu_op, rs_a, rs_b, rf_waddr},
                  {m_op, m_rd, m_rs, m_rd});
      end
      checks++;
      @(negedge clk);
      start = 1'b0;
      if ({rf_we, busy, rf_waddr, alu_op, flags, pc} !== {1'b1, 1'b1, m_rd, m_op, m_flags, m_pc}) begin
         failures++;
         $display("FAIL wb: we/busy/waddr/op/flags/pc=%b/%b/%h/%h/%h/%h want 1/1/%h/%h/%h/%h",
                  rf_we, busy, rf_waddr, alu_op, flags, pc, m_rd, m_op, m_flags, m_pc);
      end
      checks++;
      if (ins[0]) m_flags = nzcv;
      m_pc = next_pc(m_pc);
      @(negedge clk);
      if ({instr_ready, rf_we, flags, pc} !== {1'b1, 1'b0, m_flags, m_pc}) begin
         failures++;
         $display("FAIL commit: rdy/we/flags/pc=%b/%b/%h/%h want 1/0/%h/%h",
                  instr_ready, rf_we, flags, pc, m_flags, m_pc);
      end
      checks++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_flags = 4'h0; m_op = 3'd0; m_rd = 2'd0; m_rs = 2'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr = '0; alu_nzcv = '0;
      model_reset();
      #1;
      if ({instr_ready, rf_we, busy, halted, pc, alu_op, rs_a, rs_b, rf_waddr, flags} !== '0) begin
         failures++;
         $display("FAIL reset_values: got %h want 0", {instr_ready, rf_we, busy, halted, pc,
                  alu_op, rs_a, rs_b, rf_waddr, flags});
      end
      checks++;
      @(negedge clk);
      rst_n       = 1'b1;
      instr_valid = 1'b1;
      instr       = 9'b0_111_11_11_1;
      @(negedge clk);
      @(negedge clk);
      if ({instr_ready, busy, rf_we, pc, alu_op} !== '0) begin
         failures++;
         $display("FAIL idle_hold: rdy/busy/we/pc/op=%b/%b/%b/%h/%h want all 0",
                  instr_ready, busy, rf_we, pc, alu_op);
      end
      checks++;
      instr_valid = 1'b0;
      pulse_start();
   endtask

   task automatic test_basic();
      run_instr(9'b0_001_10_01_1, 0, 4'b0100, 1'b0);
      if ({flags, pc} !== {4'b0100, 8'h01}) begin
         failures++;
         $display("FAIL basic_result: flags/pc=%b/%h want 0100/01", flags, pc);
      end
      checks++;
   endtask

   task automatic test_s0();
      run_instr(9'b0_101_01_11_0, 0, 4'b1111, 1'b0);
      if (flags !== 4'b0100) begin
         failures++;
         $display("FAIL s0_flags: got %b want 0100", flags);
      end
      checks++;
   endtask

   task automatic test_stall();
      run_instr(rand_instr(), 5, 4'($urandom), 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++)
         run_instr(rand_instr(), $urandom_range(0, 2), 4'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_wrap();
      int guard;
      guard = 0;
      while (m_pc != 8'hFF && guard < 300) begin
         run_instr(rand_instr(), 0, 4'($urandom), 1'b0);
         guard++;
      end
      if (m_pc != 8'hFF) begin
         failures++;
         $display("FAIL wrap_reach: model pc %h never reached ff", m_pc);
      end
      checks++;
      run_instr(rand_instr(), 0, 4'($urandom), 1'b0);
      if (pc !== 8'h00) begin
         failures++;
         $display("FAIL wrap: pc=%h want 00", pc);
      end
      checks++;
   endtask

   task automatic test_halt();
      while (m_pc != 8'h05) run_instr(rand_instr(), 0, 4'($urandom), 1'b0);
      run_instr(9'h100, 0, 4'hF, 1'b0);
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if ({halted, busy, rf_we, pc, flags, alu_op} !== {1'b1, 1'b0, 1'b0, 8'h05, m_flags, m_op}) begin
            failures++;
            $display("FAIL halt_hold: halt/busy/we/pc/flags/op=%b/%b/%b/%h/%h/%h want 1/0/0/05/%h/%h",
                     halted, busy, rf_we, pc, flags, alu_op, m_flags, m_op);
         end
         checks++;
      end
      instr_valid = 1'b0;
      pulse_start();
      m_pc = 8'h00;
      if ({halted, instr_ready, busy, pc} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL halt_restart: halt/rdy/busy/pc=%b/%b/%b/%h want 0/1/1/00",
                  halted, instr_ready, busy, pc);
      end
      checks++;
      run_instr(rand_instr(), 1, 4'($urandom), 1'b1);
   endtask

   task automatic test_reset_in_wb();
      instr_valid = 1'b1;
      instr       = 9'b0_011_01_10_1;
      @(negedge clk);
      instr_valid = 1'b0;
      alu_nzcv    = 4'b1010;
      @(negedge clk);
      if (rf_we !== 1'b1) begin
         failures++;
         $display("FAIL pre_abort_wb: rf_we=%b want 1", rf_we);
      end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if ({rf_we, busy, halted, instr_ready, flags, pc, alu_op, rf_waddr} !== '0) begin
         failures++;
         $display("FAIL abort_wb: we/busy/halt/rdy/flags/pc/op/waddr=%b/%b/%b/%b/%h/%h/%h/%h want 0",
                  rf_we, busy, halted, instr_ready, flags, pc, alu_op, rf_waddr);
      end
      checks++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      if ({busy, flags, pc} !== '0) begin
         failures++;
         $display("FAIL after_abort_idle: busy/flags/pc=%b/%h/%h want 0", busy, flags, pc);
      end
      checks++;
      pulse_start();
      run_instr(rand_instr(), 0, 4'($urandom), 1'b1);
      run_instr(rand_instr(), 2, 4'($urandom), 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_s0();
      test_stall();
      test_random();
      test_wrap();
      test_halt();
      test_reset_in_wb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit CPU datapath. Fetches 9-bit instructions from instruction memory over a valid/ready handshake, drives the ALU opcode and register-file read/write addresses, and commits ALU results and NZCV flags on a fixed three-state cycle. Sits between instruction memory, the register file and the ALU. Owns the program counter, the architectural flags register and the halt state.

## Interface
Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value on reset and on restart from HALT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  single-cycle pulse; leaves IDLE or HALT.
- instr_valid  input  1  instruction memory has `instr` for the current `pc`.
- instr  input  9  [8]=HALT, [7:5]=alu op, [4:3]=rd, [2:1]=rs, [0]=S (update flags).
- instr_ready  output  1  high only in FETCH.
- pc  output  PC_W  address of the instruction being fetched.
- alu_op  output  3  ALU OP_Code, from the latched instruction.
- rs_a  output  2  register-file read port A address; equals rd.
- rs_b  output  2  register-file read port B address; equals rs.
- alu_nzcv  input  4  ALU flag outputs, combinational from the ALU.
- rf_we  output  1  register-file write enable, one cycle per instruction.
- rf_waddr  output  2  write address; equals rd.
- flags  output  4  architectural NZCV register.
- busy  output  1  high in FETCH, EXEC and WB.
- halted  output  1  high in HALT.

## Operation
- States:
  - IDLE: after reset.
  - FETCH: `instr_ready`=1. On `instr_valid`, latch `instr` into IR. If IR[8]=1, go to HALT. Otherwise go to EXEC.
  - EXEC: drive `alu_op`, `rs_a`, `rs_b` from IR so the datapath settles.
  - WB: `rf_we`=1. If S=1, `flags` <= `alu_nzcv` at the end of WB. `pc` <= `pc`+1 (mod 2^PC_W). Go to FETCH.
  - HALT: no outputs change. `start` sets `pc` to RESET_PC and goes to FETCH.
- IDLE + `start` -> FETCH with `pc` unchanged (=RESET_PC).
- `start` in FETCH, EXEC or WB is ignored.
- A HALT instruction does not increment `pc`. `pc` keeps the address of the HALT instruction, for debug.
- `alu_op`, `rs_a`, `rs_b`, `rf_waddr` are registered from IR. They are stable from EXEC entry through WB. They hold their last values in FETCH, IDLE and HALT.
- `instr_valid` outside FETCH has no effect. A stalled FETCH (valid low) waits indefinitely with `pc` stable.
- All eight ALU opcodes write back. With S=0, `flags` is unchanged.

## Timing
- Reset values (asynchronous): state=IDLE, `pc`=RESET_PC, IR=0, `alu_op`=000, `rs_a`=`rs_b`=`rf_waddr`=00, `rf_we`=0, `instr_ready`=0, `flags`=0000, `busy`=0, `halted`=0.
- Handshake at edge T (valid & ready). EXEC occupies cycle T+1, WB occupies T+2, FETCH (ready=1) is back at T+3.
- Throughput with memory always valid: one instruction per 3 cycles.
- `rf_we` is high exactly one cycle per non-HALT instruction, never in HALT or IDLE.
- The `flags` update and `pc` increment take effect at the same edge that ends WB.
- Reset asserted in EXEC or WB aborts the instruction: no write, no flag update, outputs go to their reset values immediately.
- PC wrap: WB at `pc`=2^PC_W-1 gives `pc`=0 in the next FETCH, with no error.

## Structure
- Package `cpu_pkg` holds:
  - the state enum (IDLE, FETCH, EXEC, WB, HALT);
  - instruction field bit positions and the HALT bit index;
  - the NZCV bit order (N=3, Z=2, C=1, V=0), shared with the ALU.
- One small sub-module is natural: `instr_decode`, a combinational split of IR into op/rd/rs/S/halt. The FSM, PC and flags register stay in `control_unit`.

## Test plan
- Reset, then `start`, then instr=9'b0_001_10_01_1 with valid held high: ready at FETCH; `alu_op`=001, `rs_a`=2, `rs_b`=1 in EXEC; `rf_we`=1 and `rf_waddr`=2 in WB; with `alu_nzcv`=4'b0100, `flags`=0100; next FETCH has `pc`=1.
- S=0 with `alu_nzcv`=1111 and prior `flags`=0100: `flags` stays 0100, `rf_we` still pulses once.
- Hold `instr_valid` low for 5 FETCH cycles: `pc` stable, `rf_we`=0 throughout, instruction proceeds normally once valid rises.
- Reach `pc`=8'hFF and run a non-HALT instruction: next `pc`=8'h00.
- instr=9'h100 at `pc`=5: `halted`=1, `busy`=0, `pc`=5, no `rf_we`. `start` then gives FETCH with `pc`=RESET_PC.
- Drop `rst_n` during WB: `rf_we` falls immediately, `flags` stay at 0000 (reset value), state=IDLE. A `start` pulse while busy is ignored.
